// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared core types: word_t, fetch FSM states, fetch step size
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    REDIR_WAIT = 2'd1,
    HALTED     = 2'd2
  } fetch_state_t;

  // Byte distance between sequential instruction fetches
  localparam word_t PC_STEP_BYTES = 32'd4;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - bundle of fetch_stage signals with fetch-side and bench-side views
interface fetch_stage_if (input logic CLK);
  import cpu_types_pkg::*;

  logic  RST;
  logic  ihit;
  word_t iload;
  logic  imemREN;
  word_t imemaddr;
  logic  pcEN;
  logic  fdEN;
  logic  fd_flush;
  logic  redirect;
  word_t redirect_pc;
  logic  halt;
  word_t fd_instr;
  word_t fd_pc;
  word_t fd_npc;
  logic  fd_valid;
  logic  fetch_halted;
  word_t perf_fetch;
  word_t perf_stall;

  modport fs (
    input  CLK, RST, ihit, iload, pcEN, fdEN, fd_flush, redirect, redirect_pc, halt,
    output imemREN, imemaddr, fd_instr, fd_pc, fd_npc, fd_valid, fetch_halted,
           perf_fetch, perf_stall
  );

  modport tb (
    input  CLK, imemREN, imemaddr, fd_instr, fd_pc, fd_npc, fd_valid, fetch_halted,
           perf_fetch, perf_stall,
    output RST, ihit, iload, pcEN, fdEN, fd_flush, redirect, redirect_pc, halt
  );

endinterface

// File: rtl/fetch_stage_fd_latch.sv
// rtl/fetch_stage_fd_latch.sv - IF/ID pipeline register with flush, halt-hold and load enable
module fd_latch
  import cpu_types_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  flush_i,
  input  logic  halted_i,
  input  logic  en_i,
  input  logic  valid_i,
  input  word_t instr_i,
  input  word_t pc_i,
  input  word_t npc_i,
  output word_t instr_o,
  output word_t pc_o,
  output word_t npc_o,
  output logic  valid_o
);

  word_t instr_q, pc_q, npc_q;
  logic  valid_q;

  // Flush beats everything; while halted the contents freeze but stop counting as valid
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_q <= '0;
      pc_q    <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      instr_q <= '0;
      pc_q    <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else if (halted_i) begin
      valid_q <= 1'b0;
    end else if (en_i) begin
      instr_q <= valid_i ? instr_i : '0;
      pc_q    <= pc_i;
      npc_q   <= npc_i;
      valid_q <= valid_i;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign npc_o   = npc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, fetch FSM and IF/ID latch; FETCH_PERF_EN adds perf counters
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000,
  parameter word_t PC_STEP = PC_STEP_BYTES
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        pcEN,
  input  logic        fdEN,
  input  logic        fd_flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] fd_instr,
  output logic [31:0] fd_pc,
  output logic [31:0] fd_npc,
  output logic        fd_valid,
  output logic        fetch_halted,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        pend_q, pend_d;
  logic         word_good;
  logic         halted;

  assign halted       = (state_q == HALTED);
  assign imemREN      = !halted;
  assign imemaddr     = pc_q;
  assign fetch_halted = halted;
  // A fetched word is only real if it arrives in RUN and is not being thrown away
  assign word_good    = ihit && (state_q == RUN) && !redirect && !halt;

  // State, PC and deferred redirect target registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      pc_q    <= PC_INIT;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  // Next fetch address; a redirect during a miss waits for the miss to return
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    case (state_q)
      RUN: begin
        if (halt) begin
          state_d = HALTED;
        end else if (redirect) begin
          if (ihit) begin
            pc_d = redirect_pc;
          end else begin
            pend_d  = redirect_pc;
            state_d = REDIR_WAIT;
          end
        end else if (ihit && pcEN) begin
          pc_d = pc_q + PC_STEP;
        end
      end
      REDIR_WAIT: begin
        if (halt) begin
          state_d = HALTED;
        end else if (ihit) begin
          // The newest target wins if another redirect lands on the returning cycle
          pc_d    = redirect ? redirect_pc : pend_q;
          state_d = RUN;
        end else if (redirect) begin
          pend_d = redirect_pc;
        end
      end
      default: begin
        state_d = HALTED;
      end
    endcase
  end

  fd_latch u_fd_latch (
    .clk_i    (CLK),
    .rst_i    (RST),
    .flush_i  (fd_flush),
    .halted_i (halted),
    .en_i     (fdEN),
    .valid_i  (word_good),
    .instr_i  (iload),
    .pc_i     (pc_q),
    .npc_i    (pc_q + PC_STEP),
    .instr_o  (fd_instr),
    .pc_o     (fd_pc),
    .npc_o    (fd_npc),
    .valid_o  (fd_valid)
  );

`ifdef FETCH_PERF_EN
  word_t perf_fetch_q, perf_stall_q;
  logic  load_good;

  assign load_good = !fd_flush && !halted && fdEN && word_good;

  // Saturating counts of delivered instructions and miss cycles
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (load_good && (perf_fetch_q != 32'hFFFF_FFFF)) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if (imemREN && !ihit && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_stall = perf_stall_q;
`else
  assign perf_fetch = 32'h0;
  assign perf_stall = 32'h0;
`endif

endmodule
